// File: rtl/hamming_pkg.sv
// Shared (7,4) Hamming definitions used by the encoder and the streaming decoder.
// Codeword layout: bits [3:0] data d0..d3, bits [6:4] parity p4..p6.
package hamming_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;

  // Syndrome values that point at a data bit; all other non-zero values hit parity.
  localparam logic [SYN_W-1:0] SYN_D0 = 3'd7;
  localparam logic [SYN_W-1:0] SYN_D1 = 3'd5;
  localparam logic [SYN_W-1:0] SYN_D2 = 3'd3;
  localparam logic [SYN_W-1:0] SYN_D3 = 3'd6;

  // Parity bits {p6,p5,p4} for a data nibble.
  function automatic logic [SYN_W-1:0] parity_f(input logic [DATA_W-1:0] d);
    return {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2]};
  endfunction

  // Syndrome {s2,s1,s0}: recomputed parity against the received parity bits.
  function automatic logic [SYN_W-1:0] syndrome_f(input logic [CODE_W-1:0] c);
    return parity_f(c[DATA_W-1:0]) ^ c[CODE_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/hamming_decode_stream_if.sv
// Codeword-in / data-out valid-ready bus of the streaming Hamming decoder.
// slave  : decoder side (consumes code_i, produces data_o)
// master : environment side (produces code_i, consumes data_o)
interface hamming_decode_stream_if;
  import hamming_pkg::*;

  logic [CODE_W-1:0] code_i;
  logic              code_valid_i;
  logic              code_ready_o;
  logic [DATA_W-1:0] data_o;
  logic [SYN_W-1:0]  syndrome_o;
  logic              err_o;
  logic              data_valid_o;
  logic              data_ready_i;

  modport slave (
    input  code_i, code_valid_i, data_ready_i,
    output code_ready_o, data_o, syndrome_o, err_o, data_valid_o
  );

  modport master (
    output code_i, code_valid_i, data_ready_i,
    input  code_ready_o, data_o, syndrome_o, err_o, data_valid_o
  );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational (7,4) Hamming syndrome generator.
// code_i     : received codeword
// syndrome_o : {s2,s1,s0}, zero when the codeword is consistent
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SYN_W-1:0]  syndrome_o
);

  assign syndrome_o = syndrome_f(code_i);

endmodule

// File: rtl/hamming_decode_stream.sv
// Streaming (7,4) Hamming decoder: two-stage valid/ready pipeline that
// corrects any single-bit error and counts corrected output transfers.
// clk_i      : clock, rising edge
// rst_i      : asynchronous active-high reset
// bus        : codeword input / corrected data output handshake (slave side)
// clr_i      : synchronous clear of corr_cnt_o (pipeline unaffected)
// corr_cnt_o : saturating count of output transfers with err_o=1
module hamming_decode_stream
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  hamming_decode_stream_if.slave  bus,
  input  logic                    clr_i,
  output logic [CNT_W-1:0]        corr_cnt_o
);

  logic              v1_q, v1_d, v2_q, v2_d;
  logic [CODE_W-1:0] code1_q, code1_d;
  logic [SYN_W-1:0]  syn1_q, syn1_d, syn_in;
  logic [DATA_W-1:0] data2_q, data2_d, corr_data;
  logic [SYN_W-1:0]  syn2_q, syn2_d;
  logic              err2_q, err2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adv1, adv2, out_xfer;

  hamming_syndrome u_syndrome (
    .code_i     (bus.code_i),
    .syndrome_o (syn_in)
  );

  // A stage may load when it is empty or the stage after it drains.
  assign adv2     = !v2_q || bus.data_ready_i;
  assign adv1     = !v1_q || adv2;
  assign out_xfer = v2_q && bus.data_ready_i;

  assign bus.code_ready_o = adv1;
  assign bus.data_valid_o = v2_q;
  assign bus.data_o       = data2_q;
  assign bus.syndrome_o   = syn2_q;
  assign bus.err_o        = err2_q;
  assign corr_cnt_o       = cnt_q;

  // Flip the data bit named by the syndrome; parity-bit hits leave data alone.
  always_comb begin
    corr_data = code1_q[DATA_W-1:0];
    case (syn1_q)
      SYN_D0:  corr_data[0] = ~code1_q[0];
      SYN_D1:  corr_data[1] = ~code1_q[1];
      SYN_D2:  corr_data[2] = ~code1_q[2];
      SYN_D3:  corr_data[3] = ~code1_q[3];
      default: ;
    endcase
  end

  // Pipeline next-state.
  always_comb begin
    v1_d    = v1_q;
    code1_d = code1_q;
    syn1_d  = syn1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    syn2_d  = syn2_q;
    err2_d  = err2_q;
    if (adv1) begin
      v1_d = bus.code_valid_i;
      if (bus.code_valid_i) begin
        code1_d = bus.code_i;
        syn1_d  = syn_in;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        data2_d = corr_data;
        syn2_d  = syn1_q;
        err2_d  = (syn1_q != '0);
      end
    end
  end

  // Corrected-transfer counter; clear has priority and the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (out_xfer && err2_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      code1_q <= '0;
      syn1_q  <= '0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      syn2_q  <= '0;
      err2_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      code1_q <= code1_d;
      syn1_q  <= syn1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      syn2_q  <= syn2_d;
      err2_q  <= err2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_decode_stream.sv
// Directed self-checking bench for hamming_decode_stream.
module tb_hamming_decode_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        sclr = 1'b0;
  logic [15:0] cnt;
  logic [1:0]  scnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output words packed as {err, syndrome[2:0], data[3:0]}.
  logic [6:0] code_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] pend;
  int         exp_cnt;

  // Syndrome produced by flipping codeword bit k.
  logic [2:0] syn_tab [0:6] = '{3'd7, 3'd5, 3'd3, 3'd6, 3'd1, 3'd2, 3'd4};

  always #5 clk = ~clk;

  hamming_decode_stream_if bus ();
  hamming_decode_stream_if sbus ();

  hamming_decode_stream #(.CNT_W(16)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .clr_i      (clr),
    .corr_cnt_o (cnt)
  );

  hamming_decode_stream #(.CNT_W(2)) u_sat (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (sbus),
    .clr_i      (sclr),
    .corr_cnt_o (scnt)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p4, p5, p6;
    p4 = d[0] ^ d[1] ^ d[2];
    p5 = d[0] ^ d[2] ^ d[3];
    p6 = d[0] ^ d[1] ^ d[3];
    return {p6, p5, p4, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of scoreboard bookkeeping; called just before the active edge.
  task automatic step();
    logic       in_x, out_x, stall;
    logic [7:0] held;
    in_x  = bus.code_valid_i && bus.code_ready_o;
    out_x = bus.data_valid_o && bus.data_ready_i;
    stall = bus.data_valid_o && !bus.data_ready_i;
    held  = {bus.err_o, bus.syndrome_o, bus.data_o};
    chk("code_ready", 32'(bus.code_ready_o), 32'((sb_q.size() < 2) || bus.data_ready_i));
    if (sb_q.size() == 0) chk("spurious_valid", 32'(bus.data_valid_o), 0);
    if (out_x && sb_q.size() != 0) begin
      logic [7:0] e;
      e = sb_q.pop_front();
      chk("out_word", 32'(held), 32'(e));
      if (e[7]) exp_cnt++;
    end
    if (in_x) sb_q.push_back(pend);
    @(posedge clk);
    #1;
    if (stall) chk("stall_hold", 32'({bus.data_valid_o, bus.err_o, bus.syndrome_o, bus.data_o}),
                   32'({1'b1, held}));
  endtask

  // Stream code_q through the decoder; cyc returns clocks until fully drained.
  task automatic run_stream(input bit rand_ready, input int budget, output int cyc);
    int   idx;
    logic take;
    idx = 0;
    cyc = 0;
    while ((idx < code_q.size() || sb_q.size() != 0) && cyc < budget) begin
      if (idx < code_q.size()) begin
        bus.code_valid_i = 1'b1;
        bus.code_i       = code_q[idx];
        pend             = exp_q[idx];
      end else begin
        bus.code_valid_i = 1'b0;
      end
      bus.data_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      take = bus.code_valid_i && bus.code_ready_o;
      step();
      if (take) idx++;
      cyc++;
    end
    bus.code_valid_i = 1'b0;
    bus.data_ready_i = 1'b1;
    chk("stream_done", 32'(idx) + 32'(code_q.size() - idx) * 32'(sb_q.size() + 1), 32'(code_q.size()));
    code_q.delete();
    exp_q.delete();
  endtask

  task automatic send_sat();
    sbus.code_i       = 7'h4A;
    sbus.code_valid_i = 1'b1;
    @(posedge clk); #1;
    sbus.code_valid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [3:0]  d;
    int          e;
    logic [1:0]  sat_exp [0:4] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    bus.code_i = '0;  bus.code_valid_i = 1'b0;  bus.data_ready_i = 1'b1;
    sbus.code_i = '0; sbus.code_valid_i = 1'b0; sbus.data_ready_i = 1'b1;
    exp_cnt = 0;
    pend = '0;

    // Reset state
    #1;
    chk("rst_valid", 32'(bus.data_valid_o), 0);
    chk("rst_data", 32'(bus.data_o), 0);
    chk("rst_syn", 32'(bus.syndrome_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_ready", 32'(bus.code_ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: clean codeword, 2-cycle latency
    bus.code_i = 7'h4B; bus.code_valid_i = 1'b1;
    #1;
    chk("t1_ready", 32'(bus.code_ready_o), 1);
    @(posedge clk); #1;
    bus.code_valid_i = 1'b0;
    chk("t1_lat1_valid", 32'(bus.data_valid_o), 0);
    @(posedge clk); #1;
    chk("t1_lat2_valid", 32'(bus.data_valid_o), 1);
    chk("t1_data", 32'(bus.data_o), 32'hB);
    chk("t1_syn", 32'(bus.syndrome_o), 0);
    chk("t1_err", 32'(bus.err_o), 0);
    @(posedge clk); #1;
    chk("t1_done_valid", 32'(bus.data_valid_o), 0);
    chk("t1_cnt", 32'(cnt), 0);

    // Test 2: every single-bit error of 7'h4B
    for (int k = 0; k < 7; k++) begin
      code_q.push_back(7'h4B ^ 7'(1 << k));
      exp_q.push_back({1'b1, syn_tab[k], 4'hB});
    end
    run_stream(1'b0, 50, cyc);
    chk("t2_cnt", 32'(cnt), 7);
    exp_cnt = 7;

    // Test 3: 16 codewords under random backpressure
    for (int k = 0; k < 16; k++) begin
      d = 4'($urandom_range(0, 15));
      e = $urandom_range(0, 7);
      if (e == 0) begin
        code_q.push_back(enc(d));
        exp_q.push_back({1'b0, 3'd0, d});
      end else begin
        code_q.push_back(enc(d) ^ 7'(1 << (e - 1)));
        exp_q.push_back({1'b1, syn_tab[e-1], d});
      end
    end
    run_stream(1'b1, 300, cyc);
    chk("t3_cnt", 32'(cnt), 32'(exp_cnt));

    // Test 4: saturation and clear priority with a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      send_sat();
      @(posedge clk); #1;
      chk("t4_sat_cnt", 32'(scnt), 32'(sat_exp[k]));
    end
    send_sat();
    chk("t4_pre_clr_valid", 32'(sbus.data_valid_o), 1);
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
    chk("t4_clr_cnt", 32'(scnt), 0);
    chk("t4_clr_xfer", 32'(sbus.data_valid_o), 0);

    // Test 5: asynchronous reset with both stages full
    bus.data_ready_i = 1'b0;
    bus.code_i = 7'h4B; bus.code_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.code_i = 7'h4A;
    @(posedge clk); #1;
    bus.code_valid_i = 1'b0;
    chk("t5_full_ready", 32'(bus.code_ready_o), 0);
    chk("t5_full_valid", 32'(bus.data_valid_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.data_valid_o), 0);
    chk("t5_rst_cnt", 32'(cnt), 0);
    chk("t5_rst_ready", 32'(bus.code_ready_o), 1);
    @(negedge clk);
    rst = 1'b0;
    bus.data_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.code_i = 7'h00; bus.code_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.code_valid_i = 1'b0;
    chk("t5_no_stale", 32'(bus.data_valid_o), 0);
    @(posedge clk); #1;
    chk("t5_valid", 32'(bus.data_valid_o), 1);
    chk("t5_data", 32'({bus.err_o, bus.syndrome_o, bus.data_o}), 0);
    @(posedge clk); #1;
    chk("t5_single", 32'(bus.data_valid_o), 0);

    // Test 6: exhaustive 16 data x 8 error patterns back-to-back
    for (int dv = 0; dv < 16; dv++) begin
      for (int ev = 0; ev < 8; ev++) begin
        if (ev == 0) begin
          code_q.push_back(enc(4'(dv)));
          exp_q.push_back({1'b0, 3'd0, 4'(dv)});
        end else begin
          code_q.push_back(enc(4'(dv)) ^ 7'(1 << (ev - 1)));
          exp_q.push_back({1'b1, syn_tab[ev-1], 4'(dv)});
        end
      end
    end
    run_stream(1'b0, 400, cyc);
    chk("t6_throughput", 32'(cyc), 130);
    chk("t6_cnt", 32'(cnt), 112);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
